// File: rtl/bitwise_operand_loader_pkg.sv
// Shared definitions for the bitwise operand loader: default widths, FSM state
// encoding and the handshake helper used by the loader datapath.
package bitwise_operand_loader_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_LOAD_A = 2'd0,
        S_LOAD_B = 2'd1,
        S_EXEC   = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    function automatic logic xfer(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/bitwise_operand_loader_wrap_counter.sv
// Free-running CNT_W-bit event counter; wraps to zero past its maximum value.
module wrap_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_r;

    // Count enabled events, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= '0;
        end else if (en) begin
            q_r <= q_r + CNT_W'(1);
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/bitwise_operand_loader.sv
// Byte-stream feeder for an external 8-bit AND gate: loads A then B, waits one
// settle cycle, captures the gate result and hands it downstream.
module bitwise_operand_loader
    import bitwise_operand_loader_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] opa,
    output logic [WIDTH-1:0] opb,
    input  logic [WIDTH-1:0] res_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             in_xfer_s;
    logic             out_xfer_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_LOAD_A;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and input-acceptance decode.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            S_LOAD_A: begin
                accept_s = 1'b1;
                if (in_valid) begin
                    state_s = S_LOAD_B;
                end else begin
                    state_s = S_LOAD_A;
                end
            end
            S_LOAD_B: begin
                accept_s = 1'b1;
                if (in_valid) begin
                    state_s = S_EXEC;
                end else begin
                    state_s = S_LOAD_B;
                end
            end
            S_EXEC: begin
                state_s = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_s = S_LOAD_A;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: begin
                state_s = S_LOAD_A;
            end
        endcase
    end

    assign in_xfer_s  = xfer(in_valid, accept_s);
    assign out_xfer_s = xfer(out_valid_r, out_ready) & (state_r == S_OUT);

    // Operand and result registers; operands only move on their own load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa_r       <= '0;
            opb_r       <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (in_xfer_s && (state_r == S_LOAD_A)) begin
                opa_r <= in_data;
            end else begin
                opa_r <= opa_r;
            end
            if (in_xfer_s && (state_r == S_LOAD_B)) begin
                opb_r <= in_data;
            end else begin
                opb_r <= opb_r;
            end
            if (state_r == S_EXEC) begin
                out_data_r  <= res_in;
                out_valid_r <= 1'b1;
            end else if (out_xfer_s) begin
                out_data_r  <= out_data_r;
                out_valid_r <= 1'b0;
            end else begin
                out_data_r  <= out_data_r;
                out_valid_r <= out_valid_r;
            end
        end
    end

    wrap_counter #(
        .CNT_W (CNT_W)
    ) u_done_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (out_xfer_s),
        .q     (done_cnt)
    );

    // Reset gates in_ready so no byte can be taken while state is being cleared.
    assign in_ready  = accept_s & ~reset;
    assign opa       = opa_r;
    assign opb       = opb_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = (state_r != S_LOAD_A);

endmodule
